// File: rtl/readout_sequencer_if.sv
// Readout sequencer bus: command decoder inputs, hit-memory read port and
// byte-serial transmitter handshake, grouped for the sequencer and its peers.
interface readout_sequencer_if #(
   parameter int unsigned IDX_W  = 2,
   parameter int unsigned DATA_W = 16
);
   logic                  cmd_read;
   logic                  cmd_reset;
   logic                  cmd_dev_sel;
   logic [4:0]            pkt_addr;
   logic [7:0]            dev_sel_byte;
   logic                  mem_rd;
   logic [5+IDX_W-1:0]    mem_addr;
   logic [DATA_W-1:0]     mem_dout;
   logic [7:0]            tx_data;
   logic                  tx_load;
   logic                  tx_rdy;
   logic                  busy;
   logic                  pkt_done;

   // Sequencer side
   modport master (
      input  cmd_read, cmd_reset, cmd_dev_sel, pkt_addr, dev_sel_byte,
      input  mem_dout, tx_rdy,
      output mem_rd, mem_addr, tx_data, tx_load, busy, pkt_done
   );

   // Environment side: command decoder, hit memory, transmitter
   modport slave (
      output cmd_read, cmd_reset, cmd_dev_sel, pkt_addr, dev_sel_byte,
      output mem_dout, tx_rdy,
      input  mem_rd, mem_addr, tx_data, tx_load, busy, pkt_done
   );
endinterface

// File: rtl/readout_sequencer.sv
// Readout sequencer: on an accepted read command sends header byte, the
// WORDS_PER_PKT words of the selected hit-memory page (MSB byte first) and
// an XOR checksum byte to the byte-serial transmitter.
module readout_sequencer #(
   parameter int unsigned WORDS_PER_PKT = 4,
   parameter int unsigned IDX_W         = 2,
   parameter int unsigned DATA_W        = 16
) (
   input logic                 clk,
   input logic                 res,
   readout_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_RD,
      S_WAIT,
      S_TX_HI,
      S_TX_LO,
      S_CKSUM,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_PKT - 1);

   state_t               state_q, state_d;
   logic [4:0]           page_q, page_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [7:0]           chk_q, chk_d;
   logic [7:0]           word_lo_q, word_lo_d;
   logic                 mem_rd_q, mem_rd_d;
   logic [5+IDX_W-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_load_q, tx_load_d;
   logic                 pkt_done_q, pkt_done_d;

   // Next-state and next registered-output values; outputs are set on entry
   // to the state that owns them, so every output comes straight from a flop.
   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      idx_d      = idx_q;
      chk_d      = chk_q;
      word_lo_d  = word_lo_q;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      tx_data_d  = tx_data_q;
      tx_load_d  = tx_load_q;
      pkt_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_read && bus.cmd_dev_sel) begin
               page_d    = bus.pkt_addr;
               idx_d     = '0;
               chk_d     = '0;
               tx_data_d = bus.dev_sel_byte;
               tx_load_d = 1'b1;
               state_d   = S_HDR;
            end
         end
         S_HDR: begin
            if (bus.tx_rdy) begin
               chk_d      = chk_q ^ tx_data_q;
               tx_load_d  = 1'b0;
               mem_rd_d   = 1'b1;
               mem_addr_d = {page_q, idx_q};
               state_d    = S_RD;
            end
         end
         S_RD: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // High byte goes straight to the transmitter; only the low byte
            // needs holding until the high byte is taken.
            tx_data_d = bus.mem_dout[DATA_W-1 -: 8];
            word_lo_d = bus.mem_dout[7:0];
            tx_load_d = 1'b1;
            state_d   = S_TX_HI;
         end
         S_TX_HI: begin
            if (bus.tx_rdy) begin
               chk_d     = chk_q ^ tx_data_q;
               tx_data_d = word_lo_q;
               state_d   = S_TX_LO;
            end
         end
         S_TX_LO: begin
            if (bus.tx_rdy) begin
               chk_d = chk_q ^ tx_data_q;
               if (idx_q == LAST_IDX) begin
                  idx_d     = '0;
                  tx_data_d = chk_q ^ tx_data_q;
                  state_d   = S_CKSUM;
               end else begin
                  idx_d      = idx_q + IDX_W'(1);
                  tx_load_d  = 1'b0;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = {page_q, idx_q + IDX_W'(1)};
                  state_d    = S_RD;
               end
            end
         end
         S_CKSUM: begin
            if (bus.tx_rdy) begin
               tx_load_d  = 1'b0;
               pkt_done_d = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; cmd_reset aborts exactly like res.
   always_ff @(posedge clk) begin
      if (res || bus.cmd_reset) begin
         state_q    <= S_IDLE;
         page_q     <= '0;
         idx_q      <= '0;
         chk_q      <= '0;
         word_lo_q  <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         tx_data_q  <= '0;
         tx_load_q  <= 1'b0;
         pkt_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         idx_q      <= idx_d;
         chk_q      <= chk_d;
         word_lo_q  <= word_lo_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         tx_data_q  <= tx_data_d;
         tx_load_q  <= tx_load_d;
         pkt_done_q <= pkt_done_d;
      end
   end

   // Drive the bus from the registers.
   always_comb begin
      bus.mem_rd   = mem_rd_q;
      bus.mem_addr = mem_addr_q;
      bus.tx_data  = tx_data_q;
      bus.tx_load  = tx_load_q;
      bus.busy     = (state_q != S_IDLE);
      bus.pkt_done = pkt_done_q;
   end

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: a packet-level model builds the expected byte
// list from the hit memory contents and checks every presented byte,
// memory address, packet latency, abort and ignore behaviour.
module tb_readout_sequencer;
   localparam int unsigned WPP    = 4;
   localparam int unsigned NBYTES = 2 * WPP + 2;

   logic        clk = 1'b0;
   logic        res;
   int          n_total = 0;
   int          n_bad   = 0;
   logic [15:0] mem [0:127];

   readout_sequencer_if #(.IDX_W(2), .DATA_W(16)) bus ();

   readout_sequencer #(
      .WORDS_PER_PKT(WPP),
      .IDX_W        (2),
      .DATA_W       (16)
   ) dut (
      .clk(clk),
      .res(res),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Hit memory: data valid only in the cycle after mem_rd, junk otherwise.
   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_dout <= mem[bus.mem_addr];
      else            bus.mem_dout <= 16'($urandom);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // mode: 0 tx_rdy always 1, 1 tx_rdy one cycle in three, 2 random.
   // intr_cyc: cycle to pulse a competing cmd_read (0 = none).
   // abort_after: pulse cmd_reset once this many bytes were taken (0 = none).
   task automatic run_pkt(input logic [4:0] page, input logic [7:0] hdr,
                          input int mode, input int intr_cyc, input int abort_after);
      logic [7:0]  exp_q[$];
      logic [7:0]  x;
      logic [15:0] w;
      int          nacc;
      int          nrd;
      int          done_cyc;
      logic        saw;
      x = hdr;
      exp_q.push_back(hdr);
      for (int i = 0; i < WPP; i++) begin
         w = mem[{page, 2'(i)}];
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
         x = x ^ w[15:8] ^ w[7:0];
      end
      exp_q.push_back(x);
      nacc = 0;
      nrd = 0;
      done_cyc = -1;

      @(negedge clk);
      bus.cmd_read     = 1'b1;
      bus.cmd_dev_sel  = 1'b1;
      bus.pkt_addr     = page;
      bus.dev_sel_byte = hdr;

      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         bus.cmd_read     = (c == intr_cyc);
         bus.pkt_addr     = 5'($urandom);
         bus.dev_sel_byte = 8'($urandom);
         if (abort_after > 0 && nacc == abort_after) begin
            bus.cmd_read  = 1'b0;
            bus.cmd_reset = 1'b1;
            @(negedge clk);
            bus.cmd_reset = 1'b0;
            check("abort_busy", 32'(bus.busy), 0);
            check("abort_tx_load", 32'(bus.tx_load), 0);
            check("abort_pkt_done", 32'(bus.pkt_done), 0);
            saw = 1'b0;
            repeat (25) begin
               @(negedge clk);
               if (bus.pkt_done || bus.busy || bus.tx_load) saw = 1'b1;
            end
            check("abort_quiet", 32'(saw), 0);
            return;
         end
         case (mode)
            0:       bus.tx_rdy = 1'b1;
            1:       bus.tx_rdy = ((c % 3) == 0);
            default: bus.tx_rdy = 1'($urandom_range(0, 1));
         endcase
         if (c == 1) check("first_tx_load", 32'(bus.tx_load), 1);
         check("busy", 32'(bus.busy), 1);
         if (bus.mem_rd) begin
            check("mem_addr", 32'(bus.mem_addr), 32'({page, 2'(nrd)}));
            nrd++;
         end
         if (bus.tx_load) begin
            if (nacc < NBYTES) check("tx_data", 32'(bus.tx_data), 32'(exp_q[nacc]));
            else               check("extra_byte", nacc, NBYTES - 1);
            if (bus.tx_rdy) nacc++;
         end
         if (bus.pkt_done) begin
            done_cyc = c;
            break;
         end
      end
      check("pkt_done_seen", 32'(done_cyc >= 0), 1);
      check("byte_count", nacc, NBYTES);
      check("read_count", nrd, WPP);
      // Counting the cmd_read cycle as 1, pkt_done is high in cycle 20.
      if (mode == 0) check("latency", done_cyc, 19);
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 0);
      check("done_pulse", 32'(bus.pkt_done), 0);
   endtask

   initial begin
      logic saw;
      for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
      mem[12] = 16'h1234;
      mem[13] = 16'h5678;
      mem[14] = 16'h9ABC;
      mem[15] = 16'hDEF0;
      res              = 1'b1;
      bus.cmd_read     = 1'b0;
      bus.cmd_reset    = 1'b0;
      bus.cmd_dev_sel  = 1'b0;
      bus.pkt_addr     = '0;
      bus.dev_sel_byte = '0;
      bus.tx_rdy       = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_tx_load", 32'(bus.tx_load), 0);
      check("rst_tx_data", 32'(bus.tx_data), 0);
      check("rst_mem_rd", 32'(bus.mem_rd), 0);
      check("rst_mem_addr", 32'(bus.mem_addr), 0);
      check("rst_pkt_done", 32'(bus.pkt_done), 0);
      res = 1'b0;

      // Reference packet at full rate, then with a slow transmitter
      run_pkt(5'h03, 8'hC2, 0, 0, 0);
      run_pkt(5'h03, 8'hC2, 1, 0, 0);

      // Board not selected: read is ignored
      @(negedge clk);
      bus.cmd_read    = 1'b1;
      bus.cmd_dev_sel = 1'b0;
      bus.pkt_addr    = 5'h07;
      saw = 1'b0;
      repeat (30) begin
         @(negedge clk);
         bus.cmd_read = 1'b0;
         if (bus.busy || bus.mem_rd || bus.tx_load) saw = 1'b1;
      end
      check("nosel_quiet", 32'(saw), 0);

      // Competing read mid-packet, then a normal one afterwards
      run_pkt(5'h0A, 8'h5A, 2, 6, 0);
      run_pkt(5'h1F, 8'hA5, 0, 0, 0);

      // Abort after the third byte, then a fresh packet
      run_pkt(5'h11, 8'h3C, 0, 0, 3);
      run_pkt(5'h11, 8'h3C, 0, 0, 0);

      // cmd_read together with cmd_reset, then with res
      @(negedge clk);
      bus.cmd_read    = 1'b1;
      bus.cmd_reset   = 1'b1;
      bus.cmd_dev_sel = 1'b1;
      @(negedge clk);
      bus.cmd_read  = 1'b0;
      bus.cmd_reset = 1'b0;
      check("rdrst_busy", 32'(bus.busy), 0);
      check("rdrst_tx_load", 32'(bus.tx_load), 0);
      res          = 1'b1;
      bus.cmd_read = 1'b1;
      @(negedge clk);
      res          = 1'b0;
      bus.cmd_read = 1'b0;
      check("rdres_busy", 32'(bus.busy), 0);
      check("rdres_tx_load", 32'(bus.tx_load), 0);

      // Randomized packets
      repeat (20) begin
         int md;
         int ic;
         int ab;
         md = int'($urandom_range(0, 2));
         ic = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : 0;
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : 0;
         run_pkt(5'($urandom), 8'($urandom), md, ic, ab);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
